// File: rtl/gbuff_pkg.sv
// rtl/gbuff_pkg.sv - shared types, mode constants and lane helper for the global buffer
package gbuff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } gbuff_state_e;

    localparam logic MODE_OVERWRITE = 1'b0;
    localparam logic MODE_ACCUM     = 1'b1;

    // Bit offset of a lane inside a packed word
    function automatic int lane_lsb(input int lane, input int lane_bits);
        return lane * lane_bits;
    endfunction

endpackage

// File: rtl/gbuff_lane_alu.sv
// rtl/gbuff_lane_alu.sv - per-lane overwrite/accumulate datapath with optional saturation
module gbuff_lane_alu
    import gbuff_pkg::*;
#(
    parameter int LANE_BITS = 32,
    parameter bit SATURATE  = 1'b0
) (
    input  logic [LANE_BITS-1:0] old_val,
    input  logic [LANE_BITS-1:0] operand,
    input  logic                 mask,
    input  logic                 mode,
    output logic [LANE_BITS-1:0] new_val
);

    logic [LANE_BITS:0]   sum_ext;
    logic                 ovf;
    logic [LANE_BITS-1:0] acc_val;

    always_comb begin
        sum_ext = {old_val[LANE_BITS-1], old_val} + {operand[LANE_BITS-1], operand};
        // Sign-extended sum overflows when its top two bits disagree
        ovf     = sum_ext[LANE_BITS] ^ sum_ext[LANE_BITS-1];
        acc_val = sum_ext[LANE_BITS-1:0];
        if (SATURATE && ovf) begin
            acc_val = sum_ext[LANE_BITS] ? {1'b1, {(LANE_BITS-1){1'b0}}}
                                         : {1'b0, {(LANE_BITS-1){1'b1}}};
        end
        if (!mask) begin
            new_val = old_val;
        end else if (mode == MODE_OVERWRITE) begin
            new_val = operand;
        end else begin
            new_val = acc_val;
        end
    end

endmodule

// File: rtl/global_buffer_acc.sv
// rtl/global_buffer_acc.sv - multi-lane output buffer with pipelined read-modify-write and clear sweep
module global_buffer_acc
    import gbuff_pkg::*;
#(
    parameter int ADDR_BITS = 14,
    parameter int LANES     = 4,
    parameter int LANE_BITS = 32,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       wr_mode,
    input  logic [ADDR_BITS-1:0]       wr_addr,
    input  logic [LANES*LANE_BITS-1:0] wr_data,
    input  logic [LANES-1:0]           wr_mask,
    input  logic                       rd_en,
    input  logic [ADDR_BITS-1:0]       rd_addr,
    output logic [LANES*LANE_BITS-1:0] rd_data,
    output logic                       rd_valid,
    input  logic                       clr_start,
    output logic                       busy,
    output logic                       clr_done
);

    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int WORD_BITS = LANES * LANE_BITS;
    localparam int CNT_BITS  = ADDR_BITS + 1;

    logic [WORD_BITS-1:0] mem [DEPTH];

    gbuff_state_e         state, state_nxt;
    logic [CNT_BITS-1:0]  clr_cnt;
    logic                 clr_last;
    logic                 wr_acc, rd_acc;
    logic                 fwd_rmw, fwd_rd;

    logic                 s1_valid;
    logic                 s1_mode;
    logic [ADDR_BITS-1:0] s1_addr;
    logic [WORD_BITS-1:0] s1_data;
    logic [LANES-1:0]     s1_mask;
    logic [WORD_BITS-1:0] s1_old;
    logic [WORD_BITS-1:0] s1_new;

    assign wr_acc   = wr_en && !busy;
    assign rd_acc   = rd_en && !busy;
    assign clr_last = (clr_cnt == CNT_BITS'(DEPTH - 1));
    // The word about to commit is newer than anything the memory can return this cycle
    assign fwd_rmw  = s1_valid && (s1_addr == wr_addr);
    assign fwd_rd   = s1_valid && (s1_addr == rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = clr_start ? DRAIN : IDLE;
            DRAIN:      state_nxt = CLEAR;
            CLEAR:      state_nxt = clr_last ? DONE : CLEAR;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        clr_done = 1'b0;
        case (state)
            DRAIN, CLEAR: busy     = 1'b1;
            DONE:         clr_done = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_OVERWRITE;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_mask  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= wr_acc;
            if (wr_acc) begin
                s1_mode <= wr_mode;
                s1_addr <= wr_addr;
                s1_data <= wr_data;
                s1_mask <= wr_mask;
            end
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= fwd_rd ? s1_new : mem[rd_addr];
            end
        end
    end

    // Storage and the RMW read port carry no reset so they map onto block RAM
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt[ADDR_BITS-1:0]] <= '0;
        end else if (s1_valid) begin
            mem[s1_addr] <= s1_new;
        end
        if (wr_acc) begin
            s1_old <= fwd_rmw ? s1_new : mem[wr_addr];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gbuff_lane_alu #(
            .LANE_BITS(LANE_BITS),
            .SATURATE (SATURATE)
        ) u_alu (
            .old_val(s1_old [lane_lsb(i, LANE_BITS) +: LANE_BITS]),
            .operand(s1_data[lane_lsb(i, LANE_BITS) +: LANE_BITS]),
            .mask   (s1_mask[i]),
            .mode   (s1_mode),
            .new_val(s1_new [lane_lsb(i, LANE_BITS) +: LANE_BITS])
        );
    end

endmodule

// File: doc/global_buffer_acc.md
Name: global_buffer_acc

Overview:
Parametrised multi-lane global buffer for the TPU output matrix C. It replaces plain store/load with a pipelined read-modify-write path: overwrite or accumulate, per-lane write mask, optional saturation, and a hardware clear sweep. It sits between the systolic-array drain and the CFU response path. The array streams partial sums into it, and the CPU side reads finished tiles out.

Parameters:
ADDR_BITS, 14, address width; DEPTH = 2**ADDR_BITS words
LANES, 4, independent lanes per word
LANE_BITS, 32, signed two's-complement lane width
SATURATE, 0, 1 = signed saturating add; 0 = modulo-2^LANE_BITS wrap

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_mode  in  1  0 = overwrite, 1 = accumulate
wr_addr  in  ADDR_BITS  write address
wr_data  in  LANES*LANE_BITS  write operand; lane i at bits [i*LANE_BITS +: LANE_BITS]
wr_mask  in  LANES  per-lane enable; masked-off lanes keep their old value
rd_en  in  1  read request
rd_addr  in  ADDR_BITS  read address
rd_data  out  LANES*LANE_BITS  read result
rd_valid  out  1  rd_data valid, single-cycle pulse
clr_start  in  1  start clearing the whole buffer to zero
busy  out  1  clear in progress; requests dropped
clr_done  out  1  single-cycle pulse when the clear completes

Behaviour:
- Reset (asynchronous): rd_data=0, rd_valid=0, busy=0, clr_done=0; FSM to IDLE; pipeline stage valid=0. Memory contents are not reset.
- Write acceptance: a write is accepted at cycle T when wr_en=1 and busy=0.
  - Stage 0 (T): register addr/data/mask/mode; issue a synchronous memory read.
  - Stage 1 (T+1): per lane, new = mask ? (mode ? old+data : data) : old. Commit at the end of T+1.
  - Every write is read-modify-write.
- Ordering: a write or read issued at T observes every write accepted before T.
  - A stage-1 result whose address matches a stage-0 RMW read or an external read is forwarded; the memory value is bypassed.
  - Back-to-back accumulates to the same address are sustained at one per cycle.
  - A write accepted in the same cycle T as a read is not visible to that read.
- Read: accepted at T when rd_en=1 and busy=0. Then rd_data is valid and rd_valid=1 at T+1. Otherwise rd_valid=0 and rd_data holds its last value. Read and write run concurrently.
- Memory: two synchronous read ports (RMW and external) and one write port. Block-RAM replication is permitted.
- Arithmetic:
  - SATURATE=0: modulo wrap.
  - SATURATE=1: clamp to [-2^(LANE_BITS-1), 2^(LANE_BITS-1)-1].
  - Overwrite never saturates.
- Clear FSM: IDLE -> DRAIN -> CLEAR -> DONE -> IDLE.
  - clr_start with busy=0 at T: a write accepted at T still commits. DRAIN at T+1 lets it finish.
  - CLEAR: address k is written 0 at T+2+k, k=0..DEPTH-1.
  - DONE at T+2+DEPTH: clr_done=1, busy=0.
  - busy=1 from T+1 through T+1+DEPTH.
  - While busy: wr_en, rd_en and clr_start are ignored and dropped; rd_valid=0.
  - clr_start in DONE is accepted (busy=0).
- Address wrap: the clear counter is ADDR_BITS+1 wide; terminal count is DEPTH-1. No wrap beyond.
- Reset during clear: the FSM aborts to IDLE and the partially cleared contents stand. No clr_done is issued.

Decomposition:
- Package gbuff_pkg:
  - FSM state enum (IDLE, DRAIN, CLEAR, DONE).
  - Mode constants MODE_OVERWRITE=0, MODE_ACCUM=1.
  - Lane slice helper function.
- Sub-module gbuff_lane_alu (one per lane, generate loop):
  - Inputs: old, operand, mask, mode.
  - Output: new value, honouring SATURATE.
  - Purely combinational.

Test Plan:
- Overwrite addr 5, data {1,2,3,4}, mask 1111 at cycle 0; read addr 5 at cycle 1 -> cycle 2 rd_valid=1, rd_data={1,2,3,4}.
- Addr 7 holds {10,10,10,10}; accumulate +5 at cycle 0 and +3 at cycle 1, read at cycle 2 -> {18,18,18,18} (forwarding path).
- Addr 9 holds {1,2,3,4}; overwrite 99 with mask 0101 -> read returns {99,2,99,4}.
- Lane 0 holds 0x7FFFFFF0, accumulate 0x20 -> SATURATE=1: 0x7FFFFFFF; SATURATE=0: 0x80000010.
- DEPTH=16, buffer filled: clr_start at cycle 0 -> busy at cycles 1..17, clr_done pulse at cycle 18; wr_en at cycle 5 dropped; all 16 reads return 0.
- rst_n low at cycle 8 of a clear -> busy=0 and rd_valid=0 immediately, no clr_done; addr 15 retains its pre-clear value.
